// File: rtl/dummy_rrm_rd_arb_if.sv
// rtl/dummy_rrm_rd_arb_if.sv - AR/R bundle between two read masters, the arbiter and memory
// slave is the arbiter's view; master is the view of whatever drives the masters and memory.
interface dummy_rrm_rd_arb_if #(
   parameter int ID_WIDTH   = 8,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic [1:0]              s_arvalid;
   logic [1:0]              s_arready;
   logic [2*ID_WIDTH-1:0]   s_arid;
   logic [2*ADDR_WIDTH-1:0] s_araddr;
   logic [15:0]             s_arlen;
   logic [1:0]              s_rvalid;
   logic [1:0]              s_rready;
   logic [ID_WIDTH-1:0]     s_rid;
   logic [DATA_WIDTH-1:0]   s_rdata;
   logic [1:0]              s_rresp;
   logic                    s_rlast;
   logic                    m_arvalid;
   logic                    m_arready;
   logic [ID_WIDTH:0]       m_arid;
   logic [ADDR_WIDTH-1:0]   m_araddr;
   logic [7:0]              m_arlen;
   logic                    m_rvalid;
   logic                    m_rready;
   logic [ID_WIDTH:0]       m_rid;
   logic [DATA_WIDTH-1:0]   m_rdata;
   logic [1:0]              m_rresp;
   logic                    m_rlast;

   modport slave (
      input  s_arvalid, s_arid, s_araddr, s_arlen, s_rready,
      input  m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
      output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
      output m_arvalid, m_arid, m_araddr, m_arlen, m_rready
   );

   modport master (
      output s_arvalid, s_arid, s_araddr, s_arlen, s_rready,
      output m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
      input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
      input  m_arvalid, m_arid, m_araddr, m_arlen, m_rready
   );
endinterface

// File: rtl/dummy_rrm_rd_arb.sv
// rtl/dummy_rrm_rd_arb.sv - two-master round-robin AXI read arbiter with per-master outstanding limit
// AR requests are registered for one cycle before issue; R beats are steered back by the ID MSB.
module dummy_rrm_rd_arb #(
   parameter int ID_WIDTH        = 8,
   parameter int ADDR_WIDTH      = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic                clk,
   input logic                rst,
   dummy_rrm_rd_arb_if.slave  bus
);
   localparam int CW = 3;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   logic [0:0]            state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic [1:0][CW-1:0]    cnt_q, cnt_d;
   logic [ID_WIDTH:0]     arid_q, arid_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]            arlen_q, arlen_d;

   logic [1:0] elig;
   logic [1:0] grant;
   logic [1:0] r_done;
   logic       rk;

   assign rk = bus.m_rid[ID_WIDTH];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         elig[i] = bus.s_arvalid[i] && (cnt_q[i] < CW'(MAX_OUTSTANDING));
      end
      grant = 2'b00;
      if (state_q == IDLE && !rst) begin
         case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   // R path is purely combinational; only the last beat of a burst frees a slot.
   assign bus.s_rvalid = rk ? {bus.m_rvalid, 1'b0} : {1'b0, bus.m_rvalid};
   assign bus.m_rready = bus.s_rready[rk];
   assign bus.s_rid    = bus.m_rid[ID_WIDTH-1:0];
   assign bus.s_rdata  = bus.m_rdata[DATA_WIDTH-1:0];
   assign bus.s_rresp  = bus.m_rresp;
   assign bus.s_rlast  = bus.m_rlast;
   assign r_done       = bus.s_rvalid & bus.s_rready & {2{bus.m_rlast}};

   assign bus.s_arready = grant;
   assign bus.m_arvalid = (state_q == ISSUE);
   assign bus.m_arid    = arid_q;
   assign bus.m_araddr  = araddr_q;
   assign bus.m_arlen   = arlen_q;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      arid_d   = arid_q;
      araddr_d = araddr_q;
      arlen_d  = arlen_q;
      if (grant != 2'b00) begin
         state_d = ISSUE;
         ptr_d   = ~grant[1];
         if (grant[1]) begin
            arid_d   = {1'b1, bus.s_arid[2*ID_WIDTH-1:ID_WIDTH]};
            araddr_d = bus.s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH];
            arlen_d  = bus.s_arlen[15:8];
         end else begin
            arid_d   = {1'b0, bus.s_arid[ID_WIDTH-1:0]};
            araddr_d = bus.s_araddr[ADDR_WIDTH-1:0];
            arlen_d  = bus.s_arlen[7:0];
         end
      end else if (state_q == ISSUE && bus.m_arready) begin
         state_d = IDLE;
      end
   end

   // A spurious last on an idle master is absorbed rather than wrapping the counter.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = cnt_q[i];
         if (grant[i] && !r_done[i]) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (r_done[i] && !grant[i] && cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         cnt_q    <= '0;
         arid_q   <= '0;
         araddr_q <= '0;
         arlen_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         arid_q   <= arid_d;
         araddr_q <= araddr_d;
         arlen_q  <= arlen_d;
      end
   end
endmodule

// File: tb/tb_dummy_rrm_rd_arb.sv
// tb/tb_dummy_rrm_rd_arb.sv - self-checking bench for dummy_rrm_rd_arb
module tb_dummy_rrm_rd_arb;
   localparam int IDW = 8;
   localparam int AW  = 16;
   localparam int DW  = 32;

   typedef struct {
      logic       rvalid;
      logic [8:0] rid;
      logic [1:0] rready;
      logic [1:0] exp_rvalid;
      logic [7:0] exp_rid;
      logic       exp_rready;
   } rvec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [32:0] sb_q[$];
   logic [32:0] exp_ar, act_ar;
   rvec_t       rv [8];
   logic [1:0]  rr_pat [8];

   dummy_rrm_rd_arb_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   dummy_rrm_rd_arb #(
      .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Issued bursts are compared in order against what the stimulus expected to win.
   always @(negedge clk) begin
      if (!rst && bus.m_arvalid && bus.m_arready) begin
         n_vec++;
         act_ar = {bus.m_arid, bus.m_araddr, bus.m_arlen};
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL ar_issue: got unexpected burst %0h, want none", act_ar);
         end else begin
            exp_ar = sb_q.pop_front();
            if (act_ar !== exp_ar) begin
               n_err++;
               $display("FAIL ar_issue: got %0h, want %0h", act_ar, exp_ar);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rv[0] = '{1'b1, 9'h1AB, 2'b10, 2'b10, 8'hAB, 1'b1};
      rv[1] = '{1'b1, 9'h1AB, 2'b01, 2'b10, 8'hAB, 1'b0};
      rv[2] = '{1'b1, 9'h034, 2'b01, 2'b01, 8'h34, 1'b1};
      rv[3] = '{1'b1, 9'h034, 2'b10, 2'b01, 8'h34, 1'b0};
      rv[4] = '{1'b0, 9'h1FF, 2'b11, 2'b00, 8'hFF, 1'b1};
      rv[5] = '{1'b0, 9'h000, 2'b00, 2'b00, 8'h00, 1'b0};
      rv[6] = '{1'b1, 9'h100, 2'b11, 2'b10, 8'h00, 1'b1};
      rv[7] = '{1'b1, 9'h0C3, 2'b11, 2'b01, 8'hC3, 1'b1};
      rr_pat = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

      bus.s_arvalid = '0; bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0;
      bus.s_rready = '0; bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rid = '0;
      bus.m_rdata = '0; bus.m_rresp = '0; bus.m_rlast = 1'b0;

      // reset state, request pending while rst is high
      #2;
      bus.s_arvalid = 2'b11;
      #1;
      chk("rst_arready", 32'(bus.s_arready), 0);
      chk("rst_arvalid", 32'(bus.m_arvalid), 0);
      chk("rst_arid",    32'(bus.m_arid), 0);
      chk("rst_araddr",  32'(bus.m_araddr), 0);
      chk("rst_arlen",   32'(bus.m_arlen), 0);
      bus.s_arvalid = 2'b00;
      cyc();
      rst = 1'b0;

      // single master 0 request, one-cycle AR latency, held while m_arready low
      cyc();
      bus.s_arvalid = 2'b01; bus.s_arid = 16'h0005; bus.s_araddr = 32'h0000_0100; bus.s_arlen = 16'h0003;
      #1;
      chk("m0_grant", 32'(bus.s_arready), 32'h1);
      sb_q.push_back({1'b0, 8'h05, 16'h0100, 8'd3});
      cyc();
      bus.s_arvalid = 2'b00;
      bus.s_araddr = 32'hFFFF_FFFF;
      #1;
      chk("m0_arvalid", 32'(bus.m_arvalid), 1);
      chk("m0_arid",    32'(bus.m_arid), 32'h005);
      chk("m0_araddr",  32'(bus.m_araddr), 32'h0100);
      chk("m0_arlen",   32'(bus.m_arlen), 3);
      chk("issue_arready", 32'(bus.s_arready), 0);
      cyc();
      chk("hold_arvalid", 32'(bus.m_arvalid), 1);
      chk("hold_araddr",  32'(bus.m_araddr), 32'h0100);
      bus.m_arready = 1'b1;
      cyc();
      chk("idle_arvalid", 32'(bus.m_arvalid), 0);

      // R routing vectors
      for (int i = 0; i < 8; i++) begin
         cyc();
         bus.m_rvalid = rv[i].rvalid;
         bus.m_rid    = rv[i].rid;
         bus.s_rready = rv[i].rready;
         bus.m_rdata  = 32'hC0DE_0000 + 32'(i);
         #1;
         chk("r_svalid", 32'(bus.s_rvalid), 32'(rv[i].exp_rvalid));
         chk("r_sid",    32'(bus.s_rid), 32'(rv[i].exp_rid));
         chk("r_mready", 32'(bus.m_rready), 32'(rv[i].exp_rready));
         chk("r_sdata",  bus.s_rdata, 32'hC0DE_0000 + 32'(i));
      end
      bus.m_rvalid = 1'b0; bus.s_rready = 2'b00;

      // both masters valid from reset: grants alternate 0,1,0,1
      cyc();
      rst = 1'b1;
      bus.s_arvalid = 2'b11; bus.s_arid = 16'h2211; bus.s_araddr = 32'h2000_1000; bus.s_arlen = 16'h0201;
      bus.m_arready = 1'b1;
      sb_q.push_back({1'b0, 8'h11, 16'h1000, 8'd1});
      sb_q.push_back({1'b1, 8'h22, 16'h2000, 8'd2});
      sb_q.push_back({1'b0, 8'h11, 16'h1000, 8'd1});
      sb_q.push_back({1'b1, 8'h22, 16'h2000, 8'd2});
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("rr_grant", 32'(bus.s_arready), 32'(rr_pat[i]));
         cyc();
      end
      bus.s_arvalid = 2'b00;

      // master 1 fills its outstanding slots after a spurious last
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      bus.m_rvalid = 1'b1; bus.m_rid = 9'h100; bus.m_rlast = 1'b1; bus.s_rready = 2'b10;
      cyc();
      bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.s_arvalid = 2'b10; bus.s_arid = 16'h3C00; bus.s_arlen = 16'h0700;
         bus.s_araddr = {16'h3000 + 16'(k * 16), 16'h0000};
         #1;
         chk("m1_grant", 32'(bus.s_arready), 32'h2);
         sb_q.push_back({1'b1, 8'h3C, 16'h3000 + 16'(k * 16), 8'd7});
         cyc();
         chk("m1_issue_arready", 32'(bus.s_arready), 0);
         cyc();
      end
      bus.s_araddr = 32'h3040_0000;
      #1;
      chk("m1_full_hold", 32'(bus.s_arready), 0);
      cyc();
      chk("m1_full_hold2", 32'(bus.s_arready), 0);
      bus.m_rvalid = 1'b1; bus.m_rid = 9'h1AB; bus.m_rlast = 1'b1; bus.s_rready = 2'b10;
      #1;
      chk("m1_last_mready", 32'(bus.m_rready), 1);
      chk("m1_last_arready", 32'(bus.s_arready), 0);
      cyc();
      bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s_rready = 2'b00;
      #1;
      chk("m1_freed_grant", 32'(bus.s_arready), 32'h2);
      sb_q.push_back({1'b1, 8'h3C, 16'h3040, 8'd7});
      cyc();
      chk("m1_fifth_arvalid", 32'(bus.m_arvalid), 1);
      bus.s_arvalid = 2'b00;
      cyc();

      // reset during ISSUE drops the request and clears pointer and counters
      bus.m_arready = 1'b0;
      bus.s_arvalid = 2'b01; bus.s_arid = 16'h0044; bus.s_araddr = 32'h0000_4444; bus.s_arlen = 16'h0004;
      #1;
      chk("pre_rst_grant", 32'(bus.s_arready), 32'h1);
      cyc();
      bus.s_arvalid = 2'b11;
      #1;
      chk("pre_rst_arvalid", 32'(bus.m_arvalid), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_arvalid", 32'(bus.m_arvalid), 0);
      chk("mid_rst_arid",    32'(bus.m_arid), 0);
      chk("mid_rst_araddr",  32'(bus.m_araddr), 0);
      chk("mid_rst_arready", 32'(bus.s_arready), 0);
      cyc();
      bus.s_arid = 16'h5544; bus.s_araddr = 32'h5555_4444; bus.s_arlen = 16'h0504;
      bus.m_arready = 1'b1;
      sb_q.push_back({1'b0, 8'h44, 16'h4444, 8'd4});
      sb_q.push_back({1'b1, 8'h55, 16'h5555, 8'd5});
      rst = 1'b0;
      #1;
      chk("post_rst_grant0", 32'(bus.s_arready), 32'h1);
      cyc();
      chk("post_rst_arvalid", 32'(bus.m_arvalid), 1);
      cyc();
      chk("post_rst_grant1", 32'(bus.s_arready), 32'h2);
      cyc();
      bus.s_arvalid = 2'b00;
      cyc();
      cyc();

      chk("sb_empty", 32'(sb_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
